// File: rtl/debounce_bank.sv
// Bank of independent switch debouncers: 2-flop sync, stable-time counter, edge pulses.
// Define DEBOUNCE_HOLD_EN to build the per-channel long-hold detector (hold_o).
module debounce_bank #(
  parameter int unsigned CHANNELS  = 4,
  parameter int unsigned CNT_BITS  = 19,
  parameter logic        RESET_VAL = 1'b0,
  parameter int unsigned HOLD_BITS = 26
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [CHANNELS-1:0] noisy_i,
  output logic [CHANNELS-1:0] clean_o,
  output logic [CHANNELS-1:0] rise_o,
  output logic [CHANNELS-1:0] fall_o,
  output logic [CHANNELS-1:0] hold_o,
  output logic [CHANNELS-1:0] busy_o
);

  localparam logic [CNT_BITS-1:0] CNT_MAX = '1;

  // Reject out-of-range configurations at elaboration.
  if (CHANNELS < 1 || CHANNELS > 32 || CNT_BITS < 1 || HOLD_BITS < 1) begin : g_bad_params
    $error("debounce_bank: illegal parameter combination");
  end

  for (genvar n = 0; n < CHANNELS; n++) begin : g_ch
    logic                s1_q;
    logic                s2_q;
    logic [CNT_BITS-1:0] cnt_q;
    logic [CNT_BITS-1:0] cnt_d;
    logic                clean_q;
    logic                clean_d;
    logic                rise_q;
    logic                fall_q;
    logic                busy_q;

    // Count only while the synchronized level disagrees; any agreement restarts from 0.
    always_comb begin
      cnt_d   = '0;
      clean_d = clean_q;
      if (s2_q != clean_q) begin
        if (cnt_q == CNT_MAX) begin
          clean_d = s2_q;
        end else begin
          cnt_d = cnt_q + CNT_BITS'(1);
        end
      end
    end

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        s1_q    <= RESET_VAL;
        s2_q    <= RESET_VAL;
        cnt_q   <= '0;
        clean_q <= RESET_VAL;
        rise_q  <= 1'b0;
        fall_q  <= 1'b0;
        busy_q  <= 1'b0;
      end else begin
        s1_q    <= noisy_i[n];
        s2_q    <= s1_q;
        cnt_q   <= cnt_d;
        clean_q <= clean_d;
        rise_q  <= clean_d & ~clean_q;
        fall_q  <= ~clean_d & clean_q;
        busy_q  <= (cnt_d != '0);
      end
    end

    assign clean_o[n] = clean_q;
    assign rise_o[n]  = rise_q;
    assign fall_o[n]  = fall_q;
    assign busy_o[n]  = busy_q;

`ifdef DEBOUNCE_HOLD_EN
    localparam logic [HOLD_BITS-1:0] HOLD_MAX  = '1;
    localparam logic [HOLD_BITS-1:0] HOLD_LAST = HOLD_MAX - HOLD_BITS'(1);

    logic [HOLD_BITS-1:0] hcnt_q;
    logic [HOLD_BITS-1:0] hcnt_d;
    logic                 hold_q;
    logic                 hold_d;

    // Saturating press-duration counter; pulse on the edge it reaches all-ones.
    always_comb begin
      hcnt_d = '0;
      hold_d = 1'b0;
      if (clean_q) begin
        hcnt_d = (hcnt_q == HOLD_MAX) ? hcnt_q : hcnt_q + HOLD_BITS'(1);
        hold_d = (hcnt_q == HOLD_LAST);
      end
    end

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        hcnt_q <= '0;
        hold_q <= 1'b0;
      end else begin
        hcnt_q <= hcnt_d;
        hold_q <= hold_d;
      end
    end

    assign hold_o[n] = hold_q;
`else
    assign hold_o[n] = 1'b0;
`endif
  end

endmodule
